// File: rtl/pkt_tx_arbiter.sv
// -----------------------------------------------------------------------------
// pkt_tx_arbiter
//
// Shares one pulse Encoder between N_REQ packet sources. Picks a winner among
// the pending requesters (round-robin), hands its packet to the Encoder with a
// one-cycle start pulse and a one-cycle acceptance pulse back to the source.
// It then follows the Encoder through its busy period and enforces a minimum
// idle gap before the next start.
//
// Optional feature (compile-time macro):
//   PKT_TX_ARBITER_PRIORITY_EN - requester 0 becomes high priority and wins
//   whenever it is pending. Round-robin then applies only to requesters
//   1..N_REQ-1, and a grant to requester 0 leaves the pointer untouched.
//   Without the macro, round-robin covers all requesters.
//
// Parameters:
//   N_REQ   - number of requesters (>= 2)
//   N_PKT   - packet width, matches the Encoder
//   GAP_CYC - idle clocks after a packet completes before the next start
//             (0 = no gap)
//   BUSY_TO - clocks to wait for enc_avail to fall after a start
//
// Ports:
//   clk         - system clock
//   rst_n       - synchronous active-low reset
//   req_valid   - per-requester packet pending
//   req_data    - packet of requester i in bits [i*N_PKT +: N_PKT]
//   req_ready   - one-hot, one-cycle acceptance pulse
//   enc_avail   - Encoder idle and able to accept a start
//   enc_start   - one-cycle start pulse to the Encoder
//   enc_data    - packet to the Encoder, stable until the return to IDLE
//   busy        - high in any state other than IDLE
//   grant_id    - index of the last accepted requester
//   timeout_err - one-cycle pulse when the Encoder never went busy
// -----------------------------------------------------------------------------
module pkt_tx_arbiter #(
    parameter int          N_REQ   = 2,
    parameter int          N_PKT   = 8,
    parameter int unsigned GAP_CYC = 500_000,
    parameter int unsigned BUSY_TO = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*N_PKT-1:0]   req_data,
    output logic [N_REQ-1:0]         req_ready,
    input  logic                     enc_avail,
    output logic                     enc_start,
    output logic [N_PKT-1:0]         enc_data,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     timeout_err
);

    localparam int ID_W = $clog2(N_REQ);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_BUSY = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;
    localparam logic [1:0] GAP       = 2'd3;

    // Last count value of each timed state; the counter restarts at 0 on
    // every state change, so a state lasting K clocks ends at count K-1.
    localparam logic [31:0] GAP_LAST = 32'(GAP_CYC - 1);
    localparam logic [31:0] TO_LAST  = 32'(BUSY_TO - 1);

    // With no gap configured the GAP state is skipped entirely.
    localparam logic [1:0] AFTER_PKT = (GAP_CYC == 0) ? IDLE : GAP;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] ptr_nxt;
    logic [ID_W-1:0] win_idx;
    logic            win_found;
    logic [ID_W:0]   cand_sum;
    logic [ID_W-1:0] cand;
    logic [31:0]     cnt;
    logic            launch;
    logic            to_hit;

    // Winner search: first pending requester at or above the pointer,
    // wrapping modulo N_REQ. The extra sum bit keeps ptr+i from overflowing
    // before the wrap when N_REQ is not a power of two.
    always_comb begin
        // NOTE: every variable gets a default before any condition so no
        // path leaves it unassigned, which would otherwise infer a latch.
        win_found = 1'b0;
        win_idx   = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // NOTE: blocking assignments here, because later lines of this
            // combinational block must see the value just computed.
            cand_sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (cand_sum >= (ID_W+1)'(N_REQ)) begin
                cand_sum = cand_sum - (ID_W+1)'(N_REQ);
            end
            cand = cand_sum[ID_W-1:0];
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        ptr_nxt = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
`ifdef PKT_TX_ARBITER_PRIORITY_EN
        // Requester 0 overrides the round-robin result. Bit 0 is clear
        // whenever the search above decides, so that search naturally
        // rotates among requesters 1..N_REQ-1 only.
        if (req_valid[0]) begin
            win_found = 1'b1;
            win_idx   = '0;
            ptr_nxt   = rr_ptr;
        end
`endif
    end

    assign launch = (state == IDLE) && enc_avail && win_found;
    assign to_hit = (state == WAIT_BUSY) && enc_avail && (cnt == TO_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (launch) state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!enc_avail)  state_nxt = WAIT_DONE;
                else if (to_hit) state_nxt = AFTER_PKT;  // treated as sent
            end
            WAIT_DONE: begin
                if (enc_avail) state_nxt = AFTER_PKT;
            end
            GAP: begin
                if (cnt == GAP_LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            enc_start   <= 1'b0;
            req_ready   <= '0;
            enc_data    <= '0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
            rr_ptr      <= '0;
            cnt         <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here updates
            // from the same pre-edge values regardless of statement order.
            state       <= state_nxt;
            busy        <= (state_nxt != IDLE);
            enc_start   <= launch;
            timeout_err <= to_hit;
            req_ready   <= launch ? (N_REQ'(1) << win_idx) : '0;

            // enc_data and grant_id only move on a grant, so they hold
            // through the whole packet and gap.
            if (launch) begin
                enc_data <= req_data[int'(win_idx)*N_PKT +: N_PKT];
                grant_id <= win_idx;
                rr_ptr   <= ptr_nxt;
            end

            // Shared timer for the busy timeout and the gap: restarts on
            // every state change and saturates instead of wrapping.
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pkt_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pkt_tx_arbiter
//
// Directed sequence with randomized data and Encoder timing. The bench is
// modeled at the packet level: the expected winner comes from the pending
// set and the pointer. The expected start time comes from the clock on
// which the Encoder finished (or timed out), plus the gap and the decision
// cycle. Outputs are sampled on the falling edge; inputs are driven there.
// -----------------------------------------------------------------------------
module tb_pkt_tx_arbiter;

    localparam int N_REQ   = 3;
    localparam int N_PKT   = 8;
    localparam int GAP_CYC = 10;
    localparam int BUSY_TO = 16;
    localparam int ID_W    = $clog2(N_REQ);

    localparam int HOLD   = 0;
    localparam int DROP   = 1;
    localparam int RANDOM = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*N_PKT-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic                   enc_avail;
    logic                   enc_start;
    logic [N_PKT-1:0]       enc_data;
    logic                   busy;
    logic [ID_W-1:0]        grant_id;
    logic                   timeout_err;

    pkt_tx_arbiter #(
        .N_REQ  (N_REQ),
        .N_PKT  (N_PKT),
        .GAP_CYC(GAP_CYC),
        .BUSY_TO(BUSY_TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .enc_avail  (enc_avail),
        .enc_start  (enc_start),
        .enc_data   (enc_data),
        .busy       (busy),
        .grant_id   (grant_id),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Number of rising edges so far; read on the falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Requester-side model and arbitration model.
    logic [N_REQ-1:0] req_v;
    logic [N_PKT-1:0] req_d [N_REQ];
    int               m_ptr;
    int               next_ok;   // earliest falling edge a start may appear
    int               rel_mode;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_reqs();
        req_valid = req_v;
        for (int i = 0; i < N_REQ; i++) req_data[i*N_PKT +: N_PKT] = req_d[i];
    endtask

    function automatic logic is_pending(input logic [N_REQ-1:0] v, input int idx);
        logic [N_REQ-1:0] sh;
        sh = v >> idx;
        return sh[0];
    endfunction

    // First pending requester at or after the pointer, wrapping around.
    function automatic int pick_winner(input logic [N_REQ-1:0] v, input int ptr);
`ifdef PKT_TX_ARBITER_PRIORITY_EN
        if (is_pending(v, 0)) return 0;
`endif
        for (int k = 0; k < N_REQ; k++) begin
            if (is_pending(v, (ptr + k) % N_REQ)) return (ptr + k) % N_REQ;
        end
        return -1;
    endfunction

    // Requester behaviour once its packet has been accepted.
    task automatic release_req(input int w);
        if (rel_mode == DROP) begin
            req_v[w] = 1'b0;
        end else if (rel_mode == RANDOM) begin
            req_v[w] = 1'($urandom_range(0, 1));
            req_d[w] = 8'($urandom);
            for (int i = 0; i < N_REQ; i++) begin
                if (i != w && !is_pending(req_v, i)) begin
                    req_v[i] = 1'($urandom_range(0, 1));
                    req_d[i] = 8'($urandom);
                end
            end
            if (req_v == '0) req_v[$urandom_range(0, N_REQ-1)] = 1'b1;
        end
        drive_reqs();
    endtask

    task automatic expect_start(output int s);
        int   exp_s;
        int   w;
        logic early;
        exp_s = (next_ok > cyc) ? next_ok : cyc + 1;
        w     = pick_winner(req_v, m_ptr);
        early = 1'b0;
        while (cyc < exp_s) begin
            if (cyc == exp_s - 1) check("busy_low_in_decision", 32'(busy), 0);
            if (enc_start || (req_ready != '0)) early = 1'b1;
            tick();
        end
        check("no_early_start", 32'(early), 0);
        check("start_pulse", 32'(enc_start), 1);
        check("ready_onehot", 32'(req_ready), 32'(1) << w);
        check("enc_data", 32'(enc_data), 32'(req_d[w]));
        check("grant_id", 32'(grant_id), 32'(w));
        check("busy_at_start", 32'(busy), 1);
        s = cyc;
`ifdef PKT_TX_ARBITER_PRIORITY_EN
        if (w != 0) m_ptr = (w + 1) % N_REQ;
`else
        m_ptr = (w + 1) % N_REQ;
`endif
        release_req(w);
    endtask

    // Encoder model: drops avail fall_d clocks after the start and keeps it
    // low for low_len clocks; fall_d < 0 means it never goes busy.
    task automatic finish_packet(input int s, input int fall_d, input int low_len);
        logic bad_busy;
        logic bad_to;
        int   r;
        bad_busy = 1'b0;
        bad_to   = 1'b0;
        if (fall_d < 0) begin
            while (cyc < s + BUSY_TO) begin
                tick();
                if (cyc == s + 1) check("pulse_one_cycle", 32'({enc_start, req_ready}), 0);
                if (cyc < s + BUSY_TO && timeout_err) bad_to = 1'b1;
                if (!busy) bad_busy = 1'b1;
            end
            check("timeout_not_early", 32'(bad_to), 0);
            check("timeout_pulse", 32'(timeout_err), 1);
            check("busy_until_timeout", 32'(bad_busy), 0);
            tick();
            check("timeout_one_cycle", 32'(timeout_err), 0);
            next_ok = s + BUSY_TO + GAP_CYC + 1;
        end else begin
            r = s + fall_d + low_len;
            if (fall_d == 0) enc_avail = 1'b0;
            while (cyc < r) begin
                tick();
                if (cyc == s + 1) check("pulse_one_cycle", 32'({enc_start, req_ready}), 0);
                if (!busy) bad_busy = 1'b1;
                if (timeout_err) bad_to = 1'b1;
                if (cyc == s + fall_d) enc_avail = 1'b0;
            end
            enc_avail = 1'b1;
            check("busy_while_encoding", 32'(bad_busy), 0);
            check("no_spurious_timeout", 32'(bad_to), 0);
            // avail seen high, then GAP_CYC gap clocks, then the decision clock
            next_ok = r + GAP_CYC + 2;
        end
    endtask

    task automatic serve(input int fall_d, input int low_len);
        int s;
        expect_start(s);
        finish_packet(s, fall_d, low_len);
    endtask

    task automatic serve_rand();
        if ($urandom_range(0, 5) == 0) serve(-1, 0);
        else serve(int'($urandom_range(0, 4)), int'($urandom_range(1, 12)));
    endtask

    task automatic drain();
        rel_mode = DROP;
        while (req_v != '0) serve_rand();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   s;
        logic early;

        rst_n     = 1'b0;
        enc_avail = 1'b1;
        req_v     = '0;
        for (int i = 0; i < N_REQ; i++) req_d[i] = '0;
        drive_reqs();
        m_ptr    = 0;
        next_ok  = 0;
        rel_mode = DROP;

        // Reset state
        repeat (3) tick();
        check("rst_enc_start", 32'(enc_start), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_enc_data", 32'(enc_data), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_timeout", 32'(timeout_err), 0);
        rst_n = 1'b1;
        repeat (2) tick();
        check("idle_no_request", 32'({busy, enc_start}), 0);

        // Single request, then a request waiting out the gap
        req_v    = 3'b001;
        req_d[0] = 8'hA5;
        drive_reqs();
        serve(1, 20);
        req_v[1] = 1'b1;
        req_d[1] = 8'($urandom);
        drive_reqs();
        serve(0, 7);

        // Encoder never goes busy, then the next request is still served
        req_v[2] = 1'b1;
        req_d[2] = 8'($urandom);
        drive_reqs();
        serve(-1, 0);
        req_v[0] = 1'b1;
        req_d[0] = 8'h3C;
        drive_reqs();
        serve(2, 4);

        // Reset while the Encoder is busy
        req_v[2] = 1'b1;
        req_d[2] = 8'h5A;
        drive_reqs();
        expect_start(s);
        enc_avail = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_enc_start", 32'(enc_start), 0);
        check("midrst_req_ready", 32'(req_ready), 0);
        check("midrst_grant_id", 32'(grant_id), 0);
        check("midrst_enc_data", 32'(enc_data), 0);
        m_ptr   = 0;
        next_ok = 0;

        // All requesters pending but the Encoder unavailable: no start
        req_v    = 3'b111;
        req_d[0] = 8'h11;
        req_d[1] = 8'h22;
        req_d[2] = 8'h33;
        rel_mode = HOLD;
        drive_reqs();
        early = 1'b0;
        repeat (4) begin
            tick();
            if (enc_start || busy || (req_ready != '0)) early = 1'b1;
        end
        check("no_start_without_avail", 32'(early), 0);
        enc_avail = 1'b1;

        // Round-robin with everyone held pending: 0x11, 0x22, 0x33, 0x11
        repeat (4) serve_rand();
        drain();

        // Two requesters held pending
        req_v    = 3'b011;
        req_d[0] = 8'($urandom);
        req_d[1] = 8'($urandom);
        rel_mode = HOLD;
        drive_reqs();
        repeat (4) serve_rand();
        drain();

        // Randomized traffic
        rel_mode = RANDOM;
        for (int i = 0; i < N_REQ; i++) req_d[i] = 8'($urandom);
        req_v = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
        drive_reqs();
        repeat (24) serve_rand();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pkt_tx_arbiter.md
Name: pkt_tx_arbiter

Overview:
- Shares the single pulse Encoder between N_REQ packet sources (e.g. switch/button source, loopback test source).
- Arbitrates among the sources and issues one start pulse per packet.
- Enforces a minimum inter-packet gap, replacing the ad-hoc rate limiter in the top level.
- Sits between the requesters and the Encoder's data/start/avail interface.

Parameters:
- N_REQ, 2, number of requesters (≥2).
- N_PKT, 8, packet data width; matches Encoder N_PKT.
- GAP_CYC, 500_000, minimum idle clocks after a packet completes before the next start; 0 = no gap.
- BUSY_TO, 16, max clocks to wait for enc_avail to fall after a start.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, reset; one clock; reset is synchronous and active-low.
- req_valid, input, N_REQ, per-requester packet pending.
- req_data, input, N_REQ*N_PKT, packet for requester i in bits [i*N_PKT +: N_PKT].
- req_ready, output, N_REQ, one-hot, one-cycle acceptance pulse.
- enc_avail, input, 1, Encoder idle and able to accept start.
- enc_start, output, 1, one-cycle start pulse to Encoder.
- enc_data, output, N_PKT, packet to Encoder; stable from the start cycle until return to IDLE.
- busy, output, 1, high in any state other than IDLE.
- grant_id, output, $clog2(N_REQ), index of the last accepted requester.
- timeout_err, output, 1, one-cycle pulse when BUSY_TO expires.

Behaviour:
- Reset values (rst_n low at posedge):
  - state = IDLE.
  - enc_start, req_ready, enc_data, grant_id, timeout_err = 0.
  - Round-robin pointer = 0; gap counter = 0.
- Reset mid-packet: immediately returns to IDLE. No req_ready is issued for a packet that has not already been acknowledged.
- All outputs are registered.
- States: IDLE, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE, when enc_avail=1 and any req_valid bit is set:
  - Winner w is the first set bit searching upward from the pointer, wrapping modulo N_REQ.
  - At the next edge: enc_start=1, req_ready[w]=1, enc_data=req_data[w], grant_id=w, pointer=(w+1) mod N_REQ, state=WAIT_BUSY.
  - Latency is 1 clock from the qualifying cycle to start/ready.
- Requester rule: hold req_valid and req_data stable until req_ready is seen. Deasserting valid earlier is a protocol violation; the behaviour is then undefined.
- enc_start and req_ready are high for exactly one cycle per packet. They are never both high for different packets.
- WAIT_BUSY:
  - If enc_avail=0, go to WAIT_DONE.
  - If BUSY_TO clocks elapse with enc_avail still 1, pulse timeout_err and go to GAP (the packet is treated as sent).
- WAIT_DONE: when enc_avail=1, go to GAP and load the gap counter with 0.
- GAP:
  - Counter increments each clock; when counter reaches GAP_CYC-1, go to IDLE.
  - If GAP_CYC=0, WAIT_DONE goes directly to IDLE.
  - Counter is 32 bits and saturates; it never wraps.
- Requests arriving in any non-IDLE state wait; none is dropped.
- Simultaneous valid requests: round-robin ensures each pending requester is served within N_REQ packets.
- If enc_avail=0 while in IDLE: no start is issued; wait.

Optional Feature:
- Macro: PKT_TX_ARBITER_PRIORITY_EN.
- Defined:
  - Requester 0 is high priority and wins whenever req_valid[0]=1 in the IDLE decision cycle.
  - Round-robin applies only among requesters 1..N_REQ-1.
  - The pointer is unchanged when requester 0 wins.
- Undefined: pure round-robin across all requesters, as described above.

Test Plan:
- Single request: GAP_CYC=10, req_valid=01, req_data[7:0]=0xA5, enc_avail=1 → after 1 clock, enc_start=1 and req_ready=01 for one cycle, enc_data=0xA5, grant_id=0. The Encoder model drops avail for 20 clocks → the next start is not earlier than 10 clocks after avail rises.
- Round-robin: N_REQ=3, all valid held continuously, data 0x11/0x22/0x33 → enc_data sequence 0x11, 0x22, 0x33, 0x11; req_ready one-hot each time.
- Gap enforcement: GAP_CYC=10, back-to-back requests → enc_start spacing = 1 (decision) + Encoder busy time + 10 clocks exactly; no start while busy=1.
- Timeout: the Encoder model never drops enc_avail after start, BUSY_TO=16 → timeout_err pulses exactly 16 clocks after enc_start, then GAP, then the next request is served.
- Reset mid-op: assert rst_n=0 for 1 clock during WAIT_DONE → next cycle busy=0, enc_start=0, req_ready=0, grant_id=0; the next request goes to requester 0 first.
- Priority macro: with PKT_TX_ARBITER_PRIORITY_EN, req_valid=11 held → requester 0 is granted every packet. Without the macro → grants alternate 0, 1, 0, 1.
